// File: rtl/fir_tb_pkg.sv
// Shared definitions for the FIR test-stream link (stimulus source and capture sink).
// Contents: capture FSM state enum, default frame geometry, 18-bit sample extremes.
package fir_tb_pkg;

    // Capture sink control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } capture_state_t;

    // Default frame geometry
    localparam int unsigned DEFAULT_LENGTH     = 60;
    localparam int unsigned DEFAULT_DATA_WIDTH = 18;

    // Extremes of an 18-bit two's-complement sample
    localparam int SAMPLE_MAX = 131071;
    localparam int SAMPLE_MIN = -131072;

endpackage : fir_tb_pkg

// File: rtl/capture_ram.sv
// Capture buffer: simple dual-port memory, one write port and one synchronous
// read port. A same-cycle read and write to one address returns the old word.
// No reset; contents are undefined until written.
// Ports:
//   clock         - write and read clock
//   we/waddr/wdata - write port
//   re/raddr      - read request; rdata updates on the next edge only when re=1
//   rdata         - registered read data, held while re=0
module capture_ram #(
    parameter int unsigned DEPTH  = 60,
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Non-blocking write and read on one edge gives read-before-write
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : capture_ram

// File: rtl/data_capture_module.sv
// Sink end of the FIR test-stream link. Stores up to `length` signed samples of
// an enable-framed stream, flags frame completion and sticky overrun, and offers
// a 1-cycle-latency read port into the capture buffer.
// Optional feature (macro CAPTURE_CHECKSUM_EN): 32-bit running sum of accepted
// samples on output `checksum`.
// Ports:
//   clock, reset       - system clock; asynchronous active-high reset
//   enable             - frame enable; low returns to IDLE and clears the frame
//   data_valid/data_in - sample strobe and signed sample
//   capture_done_flag  - length samples stored
//   sample_count       - samples stored in current frame
//   overrun_flag       - sticky; valid sample seen while full
//   rd_en/rd_addr      - read request and index
//   rd_data/rd_valid   - read result, one cycle after the request
//   checksum           - (CAPTURE_CHECKSUM_EN only) sum of accepted samples mod 2^32
module data_capture_module
    import fir_tb_pkg::*;
#(
    parameter int unsigned length     = DEFAULT_LENGTH,
    parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_W     = $clog2(length),
    parameter int unsigned CNT_W      = $clog2(length + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         data_valid,
    input  logic signed [data_width-1:0] data_in,
    output logic                         capture_done_flag,
    output logic        [CNT_W-1:0]      sample_count,
    output logic                         overrun_flag,
    input  logic                         rd_en,
    input  logic        [ADDR_W-1:0]     rd_addr,
    output logic signed [data_width-1:0] rd_data,
    output logic                         rd_valid
`ifdef CAPTURE_CHECKSUM_EN
    ,
    output logic        [31:0]           checksum
`endif
);

    capture_state_t        state;
    capture_state_t        state_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  done_nxt;
    logic                  overrun_nxt;
    logic                  accept_c;
    logic                  wr_en_c;
    logic [ADDR_W-1:0]     wr_addr_c;
    logic                  rd_hit_c;
    logic                  rd_sel;
    logic [data_width-1:0] ram_q;

    // A sample is taken only while enabled, not full and not in DONE
    assign accept_c  = enable && data_valid && (state != DONE)
                       && (32'(sample_count) < length);
    assign wr_addr_c = ADDR_W'(sample_count);
    assign rd_hit_c  = rd_en && (32'(rd_addr) < length);

    // Next-state, counter and flag logic
    always_comb begin
        state_nxt   = state;
        count_nxt   = sample_count;
        done_nxt    = capture_done_flag;
        overrun_nxt = overrun_flag;
        wr_en_c     = 1'b0;

        if (!enable) begin
            state_nxt   = IDLE;
            count_nxt   = '0;
            done_nxt    = 1'b0;
            overrun_nxt = 1'b0;
        end else begin
            case (state)
                // The IDLE->CAPTURE entry cycle also accepts, so sample 0 is not lost
                IDLE, CAPTURE: begin
                    state_nxt = CAPTURE;
                    if (accept_c) begin
                        wr_en_c   = 1'b1;
                        count_nxt = sample_count + CNT_W'(1);
                        if (32'(sample_count) == length - 1) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (data_valid) begin
                        overrun_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            sample_count      <= '0;
            capture_done_flag <= 1'b0;
            overrun_flag      <= 1'b0;
        end else begin
            state             <= state_nxt;
            sample_count      <= count_nxt;
            capture_done_flag <= done_nxt;
            overrun_flag      <= overrun_nxt;
        end
    end

    // Read qualifiers; rd_sel remembers whether the last request hit the buffer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            rd_valid <= rd_hit_c;
            if (rd_en) begin
                rd_sel <= rd_hit_c;
            end
        end
    end

    // RAM output only updates on in-range reads, so it already holds across rd_en=0
    assign rd_data = rd_sel ? ram_q : '0;

    capture_ram #(
        .DEPTH  (length),
        .WIDTH  (data_width),
        .ADDR_W (ADDR_W)
    ) u_capture_ram (
        .clock (clock),
        .we    (wr_en_c),
        .waddr (wr_addr_c),
        .wdata (data_in),
        .re    (rd_hit_c),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

`ifdef CAPTURE_CHECKSUM_EN
    // Running sum of accepted samples; overrun samples are never accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (!enable) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= checksum + 32'(data_in);
        end
    end
`endif

endmodule : data_capture_module

// File: tb/tb_data_capture_module.sv
module tb_data_capture_module;
    import fir_tb_pkg::*;

    localparam int LEN = 60;

    logic               clock;
    logic               reset;
    logic               enable;
    logic               data_valid;
    logic signed [17:0] data_in;
    logic               capture_done_flag;
    logic [5:0]         sample_count;
    logic               overrun_flag;
    logic               rd_en;
    logic [5:0]         rd_addr;
    logic signed [17:0] rd_data;
    logic               rd_valid;
`ifdef CAPTURE_CHECKSUM_EN
    logic [31:0]        checksum;
`endif

    data_capture_module dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .data_valid        (data_valid),
        .data_in           (data_in),
        .capture_done_flag (capture_done_flag),
        .sample_count      (sample_count),
        .overrun_flag      (overrun_flag),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid)
`ifdef CAPTURE_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference: frame is "full" when count reaches LEN
    int          m_buf [LEN];
    int          m_count;
    bit          m_done;
    bit          m_ovr;
    bit          m_rv;
    int          m_rd;
    logic [31:0] m_cks;

    typedef struct {
        bit en; bit dv; int din; bit re; int ra;
        int e_count; bit e_done; bit e_ovr; bit e_rv; int e_rd;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic void model_reset();
        m_count = 0; m_done = 0; m_ovr = 0; m_rv = 0; m_rd = 0; m_cks = '0;
    endfunction

    function automatic void model_clock(bit en, bit dv, int din, bit re, int ra);
        if (re) begin
            if (ra < LEN) begin m_rd = m_buf[ra]; m_rv = 1; end
            else begin m_rd = 0; m_rv = 0; end
        end else begin
            m_rv = 0;
        end
        if (!en) begin
            m_count = 0; m_done = 0; m_ovr = 0; m_cks = '0;
        end else if (m_count == LEN) begin
            if (dv) m_ovr = 1;
        end else if (dv) begin
            m_buf[m_count] = din;
            m_count++;
            m_cks = m_cks + din;
            if (m_count == LEN) m_done = 1;
        end
    endfunction

    task automatic cycle(input bit en, input bit dv, input int din, input bit re, input int ra);
        enable = en; data_valid = dv; data_in = 18'(din); rd_en = re; rd_addr = 6'(ra);
        model_clock(en, dv, din, re, ra);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"},   32'(sample_count),      32'(m_count));
        chk({tag, " done"},    32'(capture_done_flag), 32'(m_done));
        chk({tag, " overrun"}, 32'(overrun_flag),      32'(m_ovr));
        chk({tag, " rd_valid"},32'(rd_valid),          32'(m_rv));
        chk({tag, " rd_data"}, 32'(rd_data),           m_rd);
`ifdef CAPTURE_CHECKSUM_EN
        chk({tag, " checksum"}, checksum, m_cks);
`endif
    endtask

    function automatic int frame_val(int i);
        if (i < 20) return SAMPLE_MAX;
        else if (i < 40) return SAMPLE_MIN;
        else return (i - 40) * 11000 - 100000;
    endfunction

    initial begin
        for (int i = 0; i < LEN; i++) m_buf[i] = 0;
        reset = 1'b1; enable = 0; data_valid = 0; data_in = '0; rd_en = 0; rd_addr = '0;
        model_reset();
        @(posedge clock); @(posedge clock); #1;
        check_model("reset");
        reset = 1'b0;

        // Full frame: done rises exactly on the 60th accept edge
        for (int i = 0; i < LEN; i++) begin
            cycle(1, 1, frame_val(i), 0, 0);
            check_model("frame");
            if (i == LEN - 2) chk("frame done early", 32'(capture_done_flag), 0);
            if (i == LEN - 1) begin
                chk("frame done", 32'(capture_done_flag), 1);
                chk("frame count60", 32'(sample_count), 60);
            end
        end
        for (int i = 0; i < LEN; i++) begin
            cycle(1, 0, 0, 1, i);
            chk("readback valid", 32'(rd_valid), 1);
            chk("readback data", 32'(rd_data), frame_val(i));
        end

        // Overrun: sticky flag, count holds, last word untouched
        for (int i = 0; i < 3; i++) cycle(1, 1, 999, 0, 0);
        chk("overrun flag", 32'(overrun_flag), 1);
        chk("overrun count", 32'(sample_count), 60);
        cycle(1, 0, 0, 1, 59);
        chk("overrun buf59", 32'(rd_data), frame_val(59));

        // Table: abort from DONE, entry-cycle accept, read-before-write, hold, out of range
        vecs[0] = '{1'b0, 1'b1, 7,   1'b1, 60, 0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 11,  1'b1, 0,  1, 1'b0, 1'b0, 1'b1, SAMPLE_MAX};
        vecs[2] = '{1'b1, 1'b0, 22,  1'b1, 0,  1, 1'b0, 1'b0, 1'b1, 11};
        vecs[3] = '{1'b1, 1'b1, -5,  1'b0, 0,  2, 1'b0, 1'b0, 1'b0, 11};
        vecs[4] = '{1'b1, 1'b1, -6,  1'b1, 1,  3, 1'b0, 1'b0, 1'b1, -5};
        vecs[5] = '{1'b1, 1'b0, 0,   1'b1, 2,  3, 1'b0, 1'b0, 1'b1, -6};
        vecs[6] = '{1'b1, 1'b1, 100, 1'b1, 63, 4, 1'b0, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b0, 1'b1, 1,   1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 0};
        for (int v = 0; v < 8; v++) begin
            cycle(vecs[v].en, vecs[v].dv, vecs[v].din, vecs[v].re, vecs[v].ra);
            chk($sformatf("vec%0d count", v),    32'(sample_count),      32'(vecs[v].e_count));
            chk($sformatf("vec%0d done", v),     32'(capture_done_flag), 32'(vecs[v].e_done));
            chk($sformatf("vec%0d overrun", v),  32'(overrun_flag),      32'(vecs[v].e_ovr));
            chk($sformatf("vec%0d rd_valid", v), 32'(rd_valid),          32'(vecs[v].e_rv));
            chk($sformatf("vec%0d rd_data", v),  32'(rd_data),           vecs[v].e_rd);
        end

        // Abort after 25 samples, then a full frame of -1
        for (int i = 0; i < 25; i++) cycle(1, 1, i + 1, 0, 0);
        chk("abort pre count", 32'(sample_count), 25);
        cycle(0, 0, 0, 0, 0);
        check_model("abort");
        chk("abort count", 32'(sample_count), 0);
        for (int i = 0; i < LEN; i++) cycle(1, 1, -1, 0, 0);
        chk("minus1 done", 32'(capture_done_flag), 1);
`ifdef CAPTURE_CHECKSUM_EN
        chk("minus1 checksum", checksum, 32'hFFFF_FFC4);
`endif
        for (int i = 0; i < LEN; i++) begin
            cycle(1, 0, 0, 1, i);
            chk("minus1 read", 32'(rd_data), 32'hFFFF_FFFF);
        end

        // Gapped valid: done on the 119th cycle, not before
        cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 119; k++) begin
            cycle(1, (k % 2) == 0, k * 3 - 150, 0, 0);
            check_model("gapped");
            if (k == 117) chk("gapped not done", 32'(capture_done_flag), 0);
            if (k == 118) chk("gapped done", 32'(capture_done_flag), 1);
        end

        // Asynchronous reset between edges mid-frame
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, i * 7, 0, 0);
        cycle(1, 0, 0, 1, 5);
        chk("pre-reset rd_valid", 32'(rd_valid), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_model("async reset");
        @(posedge clock); #1;
        reset = 1'b0;
        cycle(0, 0, 0, 1, 60);
        chk("oor rd_valid", 32'(rd_valid), 0);
        chk("oor rd_data", 32'(rd_data), 0);

`ifdef CAPTURE_CHECKSUM_EN
        // Checksum of 20*max + 20*min + 20*0 is -20; overrun leaves it frozen
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < LEN; i++)
            cycle(1, 1, (i < 20) ? SAMPLE_MAX : ((i < 40) ? SAMPLE_MIN : 0), 0, 0);
        chk("checksum frame", checksum, 32'hFFFF_FFEC);
        cycle(1, 1, 5000, 0, 0);
        cycle(1, 1, 5000, 0, 0);
        chk("checksum frozen", checksum, 32'hFFFF_FFEC);
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            int din;
            din = int'($urandom_range(0, 262143)) - 131072;
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, din,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)));
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_capture_module
